// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and types for the instruction encoder.
// Opcode values match the base ISA major opcode map.
package riscv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } enc_t;

endpackage

// File: rtl/inst_skid_buf.sv
// Two-entry in-order buffer of {inst, addr, err} feeding the imem write port.
// Head entry drives the outputs; in_ready depends only on the registered state.
module inst_skid_buf
    import riscv_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_BASE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    buf_state_e        state_q, state_d;
    logic [31:0]       head_inst_q, head_inst_d, tail_inst_q, tail_inst_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d, tail_addr_q, tail_addr_d;
    logic              head_err_q, head_err_d, tail_err_q, tail_err_d;
    logic              push, pop;

    assign in_ready  = (state_q != BUF_TWO);
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_inst  = head_inst_q;
    assign out_addr  = head_addr_q;
    assign out_err   = head_err_q;

    always_comb begin
        state_d     = state_q;
        head_inst_d = head_inst_q;
        head_addr_d = head_addr_q;
        head_err_d  = head_err_q;
        tail_inst_d = tail_inst_q;
        tail_addr_d = tail_addr_q;
        tail_err_d  = tail_err_q;
        push        = in_valid && (state_q != BUF_TWO);
        pop         = (state_q != BUF_EMPTY) && out_ready;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    head_inst_d = in_inst;
                    head_addr_d = in_addr;
                    head_err_d  = in_err;
                    state_d     = BUF_ONE;
                end
            end
            BUF_ONE: begin
                // Simultaneous push/pop replaces the head in place.
                if (push && pop) begin
                    head_inst_d = in_inst;
                    head_addr_d = in_addr;
                    head_err_d  = in_err;
                end else if (push) begin
                    tail_inst_d = in_inst;
                    tail_addr_d = in_addr;
                    tail_err_d  = in_err;
                    state_d     = BUF_TWO;
                end else if (pop) begin
                    state_d     = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    head_inst_d = tail_inst_q;
                    head_addr_d = tail_addr_q;
                    head_err_d  = tail_err_q;
                    state_d     = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BUF_EMPTY;
            head_inst_q <= '0;
            head_addr_q <= RESET_BASE;
            head_err_q  <= 1'b0;
            tail_inst_q <= '0;
            tail_addr_q <= '0;
            tail_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_inst_q <= head_inst_d;
            head_addr_q <= head_addr_d;
            head_err_q  <= head_err_d;
            tail_inst_q <= tail_inst_d;
            tail_addr_q <= tail_addr_d;
            tail_err_q  <= tail_err_d;
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Packs RV32I field bundles into instruction words, range-checks immediates,
// and stamps each word with a sequential imem byte address.
module inst_encoder
    import riscv_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_BASE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_sticky,
    output logic [15:0]       inst_count
);

    function automatic enc_t pack_inst(
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        enc_t r;
        r.inst = NOP_INST;
        r.err  = 1'b0;
        case (op)
            OP_R: r.inst = {f7, rs2, rs1, f3, rd, op};
            OP_I, OP_L, OP_JALR, OP_SYS: begin
                r.inst = {imm[11:0], rs1, f3, rd, op};
                r.err  = (imm != {{20{imm[11]}}, imm[11:0]});
            end
            OP_S: begin
                r.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                r.err  = (imm != {{20{imm[11]}}, imm[11:0]});
            end
            OP_B: begin
                r.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                r.err  = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
            end
            OP_J: begin
                r.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                r.err  = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                r.inst = {imm[31:12], rd, op};
                r.err  = (imm[11:0] != 12'd0);
            end
            default: begin
                r.inst = NOP_INST;
                r.err  = 1'b1;
            end
        endcase
        return r;
    endfunction

    logic [ADDR_W-1:0] addr_q, addr_d, word_addr;
    logic [15:0]       count_q, count_d;
    logic              sticky_q, sticky_d;
    logic              accept, xfer;
    enc_t              enc;

    always_comb begin
        enc       = pack_inst(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        accept    = in_valid && in_ready;
        xfer      = out_valid && out_ready;
        // A same-cycle base_load redirects the word being accepted.
        word_addr = base_load ? {base_addr[ADDR_W-1:2], 2'b00} : addr_q;
        addr_d    = accept ? word_addr + ADDR_W'(4) : word_addr;
        count_d   = count_q;
        sticky_d  = sticky_q;
        if (base_load) begin
            count_d  = 16'd0;
            sticky_d = 1'b0;
        end else if (xfer) begin
            count_d  = count_q + 16'd1;
            sticky_d = sticky_q | out_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= RESET_BASE;
            count_q  <= 16'd0;
            sticky_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    assign err_sticky = sticky_q;
    assign inst_count = count_q;

    inst_skid_buf #(
        .ADDR_W     (ADDR_W),
        .RESET_BASE (RESET_BASE)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (enc.inst),
        .in_addr   (word_addr),
        .in_err    (enc.err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .out_err   (out_err)
    );

endmodule

// File: tb/tb_inst_encoder.sv
// Directed + randomized bench for inst_encoder with an in-order scoreboard
// and an independent RV32I field decoder for the random bundles.
module tb_inst_encoder;
    import riscv_pkg::*;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] RB     = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        base_load = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic        err_sticky;
    logic [15:0] inst_count;

    inst_encoder #(.ADDR_W(ADDR_W), .RESET_BASE(RB)) dut (
        .clk(clk), .rst_n(rst_n), .base_load(base_load), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .out_err(out_err), .err_sticky(err_sticky), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fields_t;

    typedef struct {
        logic [31:0] inst;
        logic        chk_inst;
        fields_t     f;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] tb_addr = RB;
    logic [15:0] tb_cnt = 0;
    logic        tb_sticky = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Recovers fields from an encoded word the way a core decoder would.
    function automatic fields_t decode(input logic [31:0] w);
        fields_t f;
        f = '0;
        f.op = w[6:0];
        case (w[6:0])
            OP_R: begin
                f.rd = w[11:7]; f.f3 = w[14:12]; f.rs1 = w[19:15];
                f.rs2 = w[24:20]; f.f7 = w[31:25];
            end
            OP_I, OP_L, OP_JALR, OP_SYS: begin
                f.rd = w[11:7]; f.f3 = w[14:12]; f.rs1 = w[19:15];
                f.imm = {{20{w[31]}}, w[31:20]};
            end
            OP_S: begin
                f.f3 = w[14:12]; f.rs1 = w[19:15]; f.rs2 = w[24:20];
                f.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            OP_B: begin
                f.f3 = w[14:12]; f.rs1 = w[19:15]; f.rs2 = w[24:20];
                f.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            OP_J: begin
                f.rd = w[11:7];
                f.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                f.rd = w[11:7];
                f.imm = {w[31:12], 12'b0};
            end
            default: ;
        endcase
        return f;
    endfunction

    // Keeps only the fields a given format actually carries.
    function automatic fields_t relevant(input fields_t i);
        fields_t f;
        f = i;
        case (i.op)
            OP_R:                        f.imm = '0;
            OP_I, OP_L, OP_JALR, OP_SYS: begin f.rs2 = '0; f.f7 = '0; end
            OP_S, OP_B:                  begin f.rd = '0; f.f7 = '0; end
            OP_J, OP_LUI, OP_AUIPC:      begin f.rs1 = '0; f.rs2 = '0; f.f3 = '0; f.f7 = '0; end
            default:                     f = '0;
        endcase
        return f;
    endfunction

    // Scoreboard: pops one expectation per transfer seen on the output side.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 64'(out_inst), 64'hDEAD_BEEF_0000_0000);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_addr", 64'(out_addr), 64'(e.addr));
                chk("out_err", 64'(out_err), 64'(e.err));
                if (e.chk_inst) chk("out_inst", 64'(out_inst), 64'(e.inst));
                else            chk("decoded_fields", decode(out_inst), e.f);
                if (!base_load) begin
                    tb_cnt++;
                    tb_sticky = tb_sticky | e.err;
                end
            end
        end
        if (rst_n && base_load) begin
            tb_cnt = 0;
            tb_sticky = 1'b0;
        end
    end

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic ci, input logic [31:0] einst,
                        input logic eerr, input logic bl, input logic [31:0] blbase);
        exp_t    e;
        fields_t f;
        int      n;
        in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        base_load = bl; base_addr = blbase;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        if (bl) tb_addr = blbase & ~32'd3;
        f = '{op: op, rd: rd, rs1: rs1, rs2: rs2, f3: f3, f7: f7, imm: imm};
        e.inst = einst; e.chk_inst = ci; e.f = relevant(f); e.addr = tb_addr; e.err = eerr;
        q.push_back(e);
        tb_addr = tb_addr + 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        base_load = 1'b0;
    endtask

    task automatic dsend(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm,
                         input logic [31:0] einst, input logic eerr);
        send(op, rd, rs1, rs2, 3'd0, 7'd0, imm, 1'b1, einst, eerr, 1'b0, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", 64'(q.size()), 64'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic do_base(input logic [31:0] b);
        base_load = 1'b1;
        base_addr = b;
        tb_addr = b & ~32'd3;
        @(posedge clk);
        #1;
        base_load = 1'b0;
    endtask

    logic [6:0] ops [10];
    logic [6:0] rop;
    logic [31:0] rimm;

    initial begin
        ops = '{OP_R, OP_I, OP_L, OP_S, OP_B, OP_J, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS};

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_inst", 64'(out_inst), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'(RB));
        chk("rst_out_err", 64'(out_err), 64'd0);
        chk("rst_sticky", 64'(err_sticky), 64'd0);
        chk("rst_count", 64'(inst_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed encodings, latency 1 on the first one
        out_ready = 1'b1;
        dsend(OP_I, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        chk("lat1_valid", 64'(out_valid), 64'd1);
        chk("lat1_inst", 64'(out_inst), 64'hFFF0_0093);
        chk("lat1_addr", 64'(out_addr), 64'd0);
        dsend(OP_B, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        dsend(OP_B, 5'd0, 5'd1, 5'd2, 32'd4096, 32'h8020_8063, 1'b1);
        dsend(OP_J, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0010_00EF, 1'b0);
        dsend(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        dsend(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);
        dsend(7'b1111111, 5'd3, 5'd4, 5'd5, 32'd0, NOP_INST, 1'b1);
        dsend(OP_I, 5'd2, 5'd3, 5'd0, 32'd2048, 32'h8001_8113, 1'b1);
        dsend(OP_S, 5'd0, 5'd2, 5'd3, 32'hFFFF_F800, 32'h8031_0023, 1'b0);
        drain();
        chk("sticky_set", 64'(err_sticky), 64'd1);
        chk("count_9", 64'(inst_count), 64'd9);
        chk("count_model", 64'(inst_count), 64'(tb_cnt));

        // base_load clears counters and restarts addressing
        do_base(32'h0000_0000);
        #1;
        chk("bl_sticky_clr", 64'(err_sticky), 64'd0);
        chk("bl_count_clr", 64'(inst_count), 64'd0);

        // Backpressure: two words fill the buffer, third waits
        out_ready = 1'b0;
        dsend(OP_I, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
        dsend(OP_I, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp_hold_inst", 64'(out_inst), 64'h0010_0093);
        chk("bp_hold_addr", 64'(out_addr), 64'd0);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        dsend(OP_I, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0193, 1'b0);
        drain();
        chk("bp_count_3", 64'(inst_count), 64'd3);

        // base_load mid-stream with a misaligned base (low bits dropped)
        out_ready = 1'b1;
        dsend(OP_I, 5'd4, 5'd0, 5'd0, 32'd4, 32'h0040_0213, 1'b0);
        dsend(OP_I, 5'd5, 5'd0, 5'd0, 32'd5, 32'h0050_0293, 1'b0);
        send(OP_I, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 1'b1, 32'h0060_0313, 1'b0, 1'b1, 32'h0000_0103);
        dsend(OP_I, 5'd7, 5'd0, 5'd0, 32'd7, 32'h0070_0393, 1'b0);
        drain();
        chk("bl_stream_count", 64'(inst_count), 64'(tb_cnt));
        chk("bl_stream_le2", 64'(inst_count <= 16'd2), 64'd1);

        // Random legal bundles checked through the field decoder
        for (int i = 0; i < 60; i++) begin
            rop = ops[$urandom_range(0, 9)];
            case (rop)
                OP_B:             rimm = {{19{1'b0}}, 13'($urandom)};
                OP_J:             rimm = {{11{1'b0}}, 21'($urandom)};
                OP_LUI, OP_AUIPC: rimm = $urandom & 32'hFFFF_F000;
                OP_R:             rimm = $urandom;
                default:          rimm = {{20{1'b0}}, 12'($urandom)};
            endcase
            case (rop)
                OP_B:   rimm = {{19{rimm[12]}}, rimm[12:1], 1'b0};
                OP_J:   rimm = {{11{rimm[20]}}, rimm[20:1], 1'b0};
                OP_LUI, OP_AUIPC, OP_R: ;
                default: rimm = {{20{rimm[11]}}, rimm[11:0]};
            endcase
            out_ready = ($urandom_range(0, 3) != 0) || !in_ready;
            send(rop, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                 rimm, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        end
        drain();
        chk("rand_count", 64'(inst_count), 64'(tb_cnt));
        chk("rand_sticky", 64'(err_sticky), 64'(tb_sticky));

        // Async reset with two words buffered
        out_ready = 1'b0;
        dsend(OP_I, 5'd1, 5'd0, 5'd0, 32'd9, 32'h0090_0093, 1'b0);
        dsend(OP_I, 5'd2, 5'd0, 5'd0, 32'd9, 32'h0090_0113, 1'b0);
        chk("pre_rst_full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        q.delete();
        tb_addr = RB;
        tb_cnt = 0;
        tb_sticky = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_addr", 64'(out_addr), 64'(RB));
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_count", 64'(inst_count), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        dsend(OP_I, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        drain();
        chk("post_rst_count", 64'(inst_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
